// File: rtl/axi_slv_pkg.sv
// Shared definitions for the AXI slave memory.
// Contents: burst and response encodings, write/read FSM state enums,
// the latched-command struct, and a helper that validates WRAP lengths.
package axi_slv_pkg;

    // Field widths of the latched command; the top-level ID_W / ADDR_W
    // parameters are expected to match these.
    localparam int CMD_ID_W   = 4;
    localparam int CMD_ADDR_W = 32;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic [CMD_ID_W-1:0]   id;
        logic [CMD_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_cmd_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI bus bundle between a master and axi_slave_mem.
// Channels: AW, W, B (write) and AR, R (read). Clock and reset are not
// part of the bundle. Modports: master (initiator side), slave (memory side).
interface axi_slave_mem_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [7:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [ID_W-1:0]     WID;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [7:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic [DATA_W/8-1:0] RSTRB;
    logic                RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, RSTRB,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, RSTRB,
        input  RREADY
    );

endinterface

// File: rtl/axi_addr_gen.sv
// Combinational AXI beat-address unit.
// Inputs : addr_i (current beat address), len_i, size_i, burst_i.
// Outputs: next_addr_o (address of the following beat),
//          err_o (current beat must answer SLVERR: illegal command or
//          address beyond the memory).
module axi_addr_gen
    import axi_slv_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * 4);

    logic [ADDR_W-1:0] step_s;
    logic [ADDR_W-1:0] incr_s;
    logic [ADDR_W-1:0] wrap_mask_s;
    logic              cmd_err_s;

    // Next-address computation and legality check for the current beat.
    always_comb begin
        step_s      = ADDR_W'(1) << size_i;
        incr_s      = addr_i + step_s;
        // Wrap window is (LEN+1)*step bytes, aligned to its own size.
        wrap_mask_s = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);

        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = incr_s;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask_s) | (incr_s & wrap_mask_s);
            default:     next_addr_o = addr_i;
        endcase

        cmd_err_s = (size_i > 3'd2) || (burst_i == 2'b11) ||
                    ((burst_i == BURST_WRAP) && !wrap_len_ok(len_i));
        err_o     = cmd_err_s || (addr_i >= MEM_BYTES);
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave backed by a byte-enabled word memory.
// Ports: clk, rst_n (async active-low), s_axi (slave modport carrying the
// AW/W/B/AR/R channels). Write and read paths are independent FSMs, so one
// write and one read burst may be in flight together. All outputs are
// registered; memory contents survive reset.
module axi_slave_mem
    import axi_slv_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    axi_slave_mem_if.slave s_axi
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [31:0] mem_q [MEM_WORDS];

    // ---------------- write path state ----------------
    wr_state_e       wr_state_q, wr_state_d;
    axi_cmd_t        wr_cmd_q, wr_cmd_d;
    logic [7:0]      wr_beat_q, wr_beat_d;
    logic            wr_err_q, wr_err_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic [1:0]      bresp_q, bresp_d;

    logic [ADDR_W-1:0] wr_next_addr_s;
    logic              wr_beat_err_s;
    logic              wr_last_s;
    logic              mem_we_s;
    logic [IDX_W-1:0]  mem_widx_s;
    logic [31:0]       mem_wdata_s;

    // ---------------- read path state ----------------
    rd_state_e       rd_state_q, rd_state_d;
    axi_cmd_t        rd_cmd_q, rd_cmd_d;    // addr holds the next beat to launch
    logic [7:0]      rd_beat_q, rd_beat_d;
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic            rlast_q, rlast_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [3:0]      rstrb_q, rstrb_d;

    logic [ADDR_W-1:0] rd_gen_addr_s;
    logic [7:0]        rd_gen_len_s;
    logic [2:0]        rd_gen_size_s;
    logic [1:0]        rd_gen_burst_s;
    logic [ADDR_W-1:0] rd_next_addr_s;
    logic              rd_beat_err_s;
    logic [IDX_W-1:0]  rd_ridx_s;

    // Only one write is ever outstanding, so WID carries no information.
    logic unused_wid_s;
    assign unused_wid_s = ^s_axi.WID;

    axi_addr_gen #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) u_wr_addr_gen (
        .addr_i      (ADDR_W'(wr_cmd_q.addr)),
        .len_i       (wr_cmd_q.len),
        .size_i      (wr_cmd_q.size),
        .burst_i     (wr_cmd_q.burst),
        .next_addr_o (wr_next_addr_s),
        .err_o       (wr_beat_err_s)
    );

    axi_addr_gen #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) u_rd_addr_gen (
        .addr_i      (rd_gen_addr_s),
        .len_i       (rd_gen_len_s),
        .size_i      (rd_gen_size_s),
        .burst_i     (rd_gen_burst_s),
        .next_addr_o (rd_next_addr_s),
        .err_o       (rd_beat_err_s)
    );

    // Write FSM next-state, memory write enable and byte merge.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cmd_d   = wr_cmd_q;
        wr_beat_d  = wr_beat_q;
        wr_err_d   = wr_err_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        mem_we_s   = 1'b0;
        wr_last_s  = (wr_beat_q == wr_cmd_q.len);
        mem_widx_s = wr_cmd_q.addr[IDX_W+1:2];
        for (int b = 0; b < 4; b++) begin
            mem_wdata_s[8*b +: 8] = s_axi.WSTRB[b] ? s_axi.WDATA[8*b +: 8]
                                                   : mem_q[mem_widx_s][8*b +: 8];
        end

        case (wr_state_q)
            WR_IDLE: begin
                if (s_axi.AWVALID && awready_q) begin
                    wr_cmd_d.id    = CMD_ID_W'(s_axi.AWID);
                    wr_cmd_d.addr  = CMD_ADDR_W'(s_axi.AWADDR);
                    wr_cmd_d.len   = s_axi.AWLEN;
                    wr_cmd_d.size  = s_axi.AWSIZE;
                    wr_cmd_d.burst = s_axi.AWBURST;
                    wr_beat_d      = 8'd0;
                    wr_err_d       = 1'b0;
                    awready_d      = 1'b0;
                    wready_d       = 1'b1;
                    wr_state_d     = WR_DATA;
                end else begin
                    awready_d = 1'b1;
                end
            end
            WR_DATA: begin
                if (s_axi.WVALID && wready_q) begin
                    mem_we_s      = !wr_beat_err_s;
                    // Any beat error or a WLAST that disagrees with the
                    // beat count poisons the whole burst's response.
                    wr_err_d      = wr_err_q | wr_beat_err_s | (s_axi.WLAST != wr_last_s);
                    wr_cmd_d.addr = CMD_ADDR_W'(wr_next_addr_s);
                    wr_beat_d     = wr_beat_q + 8'd1;
                    if (wr_last_s) begin
                        wready_d   = 1'b0;
                        bvalid_d   = 1'b1;
                        bid_d      = ID_W'(wr_cmd_q.id);
                        bresp_d    = wr_err_d ? RESP_SLVERR : RESP_OKAY;
                        wr_state_d = WR_RESP;
                    end else begin
                        wready_d = 1'b1;
                    end
                end else begin
                    wready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (s_axi.BREADY && bvalid_q) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wr_state_d = WR_IDLE;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: begin
                wr_state_d = WR_IDLE;
                awready_d  = 1'b0;
                wready_d   = 1'b0;
                bvalid_d   = 1'b0;
            end
        endcase
    end

    // Write FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            wr_cmd_q   <= '0;
            wr_beat_q  <= 8'd0;
            wr_err_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= 2'b00;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cmd_q   <= wr_cmd_d;
            wr_beat_q  <= wr_beat_d;
            wr_err_q   <= wr_err_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Memory array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_widx_s] <= mem_wdata_s;
        end
    end

    // The read address unit sees the incoming AR command while idle (first
    // beat launches on the AR handshake) and the latched command otherwise.
    always_comb begin
        case (rd_state_q)
            RD_IDLE: begin
                rd_gen_addr_s  = s_axi.ARADDR;
                rd_gen_len_s   = s_axi.ARLEN;
                rd_gen_size_s  = s_axi.ARSIZE;
                rd_gen_burst_s = s_axi.ARBURST;
            end
            default: begin
                rd_gen_addr_s  = ADDR_W'(rd_cmd_q.addr);
                rd_gen_len_s   = rd_cmd_q.len;
                rd_gen_size_s  = rd_cmd_q.size;
                rd_gen_burst_s = rd_cmd_q.burst;
            end
        endcase
        rd_ridx_s = rd_gen_addr_s[IDX_W+1:2];
    end

    // Read FSM next-state and beat launch.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cmd_d   = rd_cmd_q;
        rd_beat_d  = rd_beat_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rstrb_d    = rstrb_q;

        case (rd_state_q)
            RD_IDLE: begin
                if (s_axi.ARVALID && arready_q) begin
                    rd_cmd_d.id    = CMD_ID_W'(s_axi.ARID);
                    rd_cmd_d.addr  = CMD_ADDR_W'(rd_next_addr_s);
                    rd_cmd_d.len   = s_axi.ARLEN;
                    rd_cmd_d.size  = s_axi.ARSIZE;
                    rd_cmd_d.burst = s_axi.ARBURST;
                    rd_beat_d      = 8'd0;
                    arready_d      = 1'b0;
                    rvalid_d       = 1'b1;
                    rlast_d        = (s_axi.ARLEN == 8'd0);
                    rid_d          = s_axi.ARID;
                    rdata_d        = rd_beat_err_s ? 32'h0 : mem_q[rd_ridx_s];
                    rresp_d        = rd_beat_err_s ? RESP_SLVERR : RESP_OKAY;
                    rstrb_d        = 4'hF;
                    rd_state_d     = RD_DATA;
                end else begin
                    arready_d = 1'b1;
                end
            end
            RD_DATA: begin
                if (s_axi.RREADY && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d   = 1'b0;
                        rlast_d    = 1'b0;
                        arready_d  = 1'b1;
                        rd_state_d = RD_IDLE;
                    end else begin
                        rd_cmd_d.addr = CMD_ADDR_W'(rd_next_addr_s);
                        rd_beat_d     = rd_beat_q + 8'd1;
                        rlast_d       = ((rd_beat_q + 8'd1) == rd_cmd_q.len);
                        rid_d         = ID_W'(rd_cmd_q.id);
                        rdata_d       = rd_beat_err_s ? 32'h0 : mem_q[rd_ridx_s];
                        rresp_d       = rd_beat_err_s ? RESP_SLVERR : RESP_OKAY;
                        rstrb_d       = 4'hF;
                    end
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
                arready_d  = 1'b0;
                rvalid_d   = 1'b0;
                rlast_d    = 1'b0;
            end
        endcase
    end

    // Read FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            rd_cmd_q   <= '0;
            rd_beat_q  <= 8'd0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= 32'h0;
            rresp_q    <= 2'b00;
            rstrb_q    <= 4'h0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cmd_q   <= rd_cmd_d;
            rd_beat_q  <= rd_beat_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rstrb_q    <= rstrb_d;
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BID     = bid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RLAST   = rlast_q;
    assign s_axi.RID     = rid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;
    assign s_axi.RSTRB   = rstrb_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
module tb_axi_slave_mem;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    axi_slave_mem_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) bus ();

    axi_slave_mem #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_WORDS(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axi (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        @(negedge clk);
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
        bus.AWVALID = 1'b1;
        n = 0;
        while (bus.AWREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL aw_timeout: AWREADY never high, addr %h", addr); end
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        @(negedge clk);
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst;
        bus.ARVALID = 1'b1;
        n = 0;
        while (bus.ARREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL ar_timeout: ARREADY never high, addr %h", addr); end
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        @(negedge clk);
        bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
        n = 0;
        while (bus.WREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL w_timeout: WREADY never high, data %h", data); end
        @(posedge clk); #1;
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
    endtask

    task automatic b_recv(output logic [3:0] id, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.BREADY = 1'b1;
        n = 0;
        while (bus.BVALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL b_timeout: BVALID never high"); end
        id = bus.BID; resp = bus.BRESP;
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
    endtask

    task automatic r_recv(output logic [31:0] data, output logic [1:0] resp,
                          output logic last, output logic [3:0] id);
        int n;
        @(negedge clk);
        bus.RREADY = 1'b1;
        n = 0;
        while (bus.RVALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL r_timeout: RVALID never high"); end
        data = bus.RDATA; resp = bus.RRESP; last = bus.RLAST; id = bus.RID;
        @(posedge clk); #1;
        bus.RREADY = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID, bus.RLAST} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID, bus.RLAST});
        end
        checks++;
        if ({bus.BID, bus.BRESP, bus.RID, bus.RDATA, bus.RRESP, bus.RSTRB} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0",
                     {bus.BID, bus.BRESP, bus.RID, bus.RDATA, bus.RRESP, bus.RSTRB});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.AWREADY, bus.ARREADY, bus.WREADY} !== 3'b110) begin
            errors++;
            $display("FAIL reset_release: AW/AR/WREADY got %b expected 110",
                     {bus.AWREADY, bus.ARREADY, bus.WREADY});
        end
    endtask

    task automatic test_single();
        logic [31:0] d; logic [1:0] r; logic l; logic [3:0] id;
        aw_send(4'd3, 32'h10, 8'd0, 3'd2, 2'b01);
        checks++;
        if (bus.WREADY !== 1'b1) begin errors++; $display("FAIL single_wready: got %b expected 1", bus.WREADY); end
        w_send(32'hDEADBEEF, 4'hF, 1'b1);
        checks++;
        if (bus.BVALID !== 1'b1) begin errors++; $display("FAIL single_bvalid: got %b expected 1", bus.BVALID); end
        b_recv(id, r);
        checks++;
        if ({id, r} !== {4'd3, 2'b00}) begin errors++; $display("FAIL single_b: bid/bresp got %h/%b expected 3/00", id, r); end
        ar_send(4'd5, 32'h10, 8'd0, 3'd2, 2'b01);
        checks++;
        if (bus.RVALID !== 1'b1) begin errors++; $display("FAIL single_rvalid: got %b expected 1", bus.RVALID); end
        r_recv(d, r, l, id);
        checks++;
        if ({d, r, l, id} !== {32'hDEADBEEF, 2'b00, 1'b1, 4'd5}) begin
            errors++; $display("FAIL single_r: data/resp/last/id got %h/%b/%b/%h expected deadbeef/00/1/5", d, r, l, id);
        end
        checks++;
        if (bus.RSTRB !== 4'hF) begin errors++; $display("FAIL single_rstrb: got %h expected f", bus.RSTRB); end
        // partial strobe merge: bytes 0 and 2 replaced
        aw_send(4'd1, 32'h10, 8'd0, 3'd2, 2'b01);
        w_send(32'h11223344, 4'b0101, 1'b1);
        b_recv(id, r);
        ar_send(4'd1, 32'h10, 8'd0, 3'd2, 2'b01);
        r_recv(d, r, l, id);
        checks++;
        if (d !== 32'hDE22BE44) begin errors++; $display("FAIL strobe_merge: got %h expected de22be44", d); end
    endtask

    task automatic test_incr_backpressure();
        logic [1:0] r; logic [3:0] id;
        aw_send(4'd2, 32'h0, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) w_send(32'(i + 1), 4'hF, (i == 3));
        b_recv(id, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b expected 00", r); end
        ar_send(4'd2, 32'h0, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.RREADY = 1'b1;
            checks++;
            if ({bus.RVALID, bus.RDATA, bus.RLAST} !== {1'b1, 32'(i + 1), (i == 3)}) begin
                errors++; $display("FAIL incr_beat%0d: valid/data/last got %b/%h/%b expected 1/%h/%b",
                                   i, bus.RVALID, bus.RDATA, bus.RLAST, i + 1, (i == 3));
            end
            @(negedge clk);
            bus.RREADY = 1'b0;
            checks++;
            if (i < 3) begin
                if ({bus.RVALID, bus.RDATA} !== {1'b1, 32'(i + 2)}) begin
                    errors++; $display("FAIL incr_stall%0d: valid/data got %b/%h expected 1/%h", i, bus.RVALID, bus.RDATA, i + 2);
                end
            end else begin
                if ({bus.RVALID, bus.ARREADY} !== 2'b01) begin
                    errors++; $display("FAIL incr_end: rvalid/arready got %b expected 01", {bus.RVALID, bus.ARREADY});
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d; logic [1:0] r; logic l; logic [3:0] id;
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h102; exp_d[1] = 32'h103; exp_d[2] = 32'h100; exp_d[3] = 32'h101;
        aw_send(4'd0, 32'h0, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) w_send(32'h100 + 32'(i), 4'hF, (i == 3));
        b_recv(id, r);
        ar_send(4'd7, 32'h8, 8'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++) begin
            r_recv(d, r, l, id);
            checks++;
            if ({d, r, l} !== {exp_d[i], 2'b00, (i == 3)}) begin
                errors++; $display("FAIL wrap_beat%0d: data/resp/last got %h/%b/%b expected %h/00/%b", i, d, r, l, exp_d[i], (i == 3));
            end
        end
    endtask

    task automatic test_err_addr();
        logic [31:0] d; logic [1:0] r; logic l; logic [3:0] id;
        aw_send(4'd1, 32'h1000, 8'd0, 3'd2, 2'b01);
        w_send(32'hFFFFFFFF, 4'hF, 1'b1);
        b_recv(id, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL oob_bresp: got %b expected 10", r); end
        // burst straddling the memory top: beat 0 valid, beat 1 out of range
        aw_send(4'd1, 32'hFFC, 8'd1, 3'd2, 2'b01);
        w_send(32'h77, 4'hF, 1'b0);
        w_send(32'h88, 4'hF, 1'b1);
        b_recv(id, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL cross_bresp: got %b expected 10", r); end
        ar_send(4'd1, 32'hFFC, 8'd1, 3'd2, 2'b01);
        r_recv(d, r, l, id);
        checks++;
        if ({d, r, l} !== {32'h77, 2'b00, 1'b0}) begin errors++; $display("FAIL cross_r0: got %h/%b/%b expected 77/00/0", d, r, l); end
        r_recv(d, r, l, id);
        checks++;
        if ({d, r, l} !== {32'h0, 2'b10, 1'b1}) begin errors++; $display("FAIL cross_r1: got %h/%b/%b expected 0/10/1", d, r, l); end
        ar_send(4'd1, 32'h0, 8'd0, 3'd2, 2'b01);
        r_recv(d, r, l, id);
        checks++;
        if ({d, r} !== {32'h100, 2'b00}) begin errors++; $display("FAIL oob_no_alias: word0 got %h/%b expected 100/00", d, r); end
        ar_send(4'd1, 32'h1000, 8'd0, 3'd2, 2'b01);
        r_recv(d, r, l, id);
        checks++;
        if ({d, r} !== {32'h0, 2'b10}) begin errors++; $display("FAIL oob_read: got %h/%b expected 0/10", d, r); end
    endtask

    task automatic test_err_cmd();
        logic [31:0] d; logic [1:0] r; logic l; logic [3:0] id;
        ar_send(4'd2, 32'h0, 8'd1, 3'd3, 2'b01);
        for (int i = 0; i < 2; i++) begin
            r_recv(d, r, l, id);
            checks++;
            if ({d, r, l} !== {32'h0, 2'b10, (i == 1)}) begin
                errors++; $display("FAIL size3_beat%0d: got %h/%b/%b expected 0/10/%b", i, d, r, l, (i == 1));
            end
        end
        aw_send(4'd2, 32'h20, 8'd0, 3'd2, 2'b11);
        w_send(32'h5, 4'hF, 1'b1);
        b_recv(id, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL burst11_bresp: got %b expected 10", r); end
        aw_send(4'd2, 32'h20, 8'd1, 3'd2, 2'b01);
        w_send(32'h1, 4'hF, 1'b1);
        w_send(32'h2, 4'hF, 1'b1);
        b_recv(id, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL early_wlast: got %b expected 10", r); end
        aw_send(4'd2, 32'h20, 8'd0, 3'd2, 2'b01);
        w_send(32'h3, 4'hF, 1'b0);
        b_recv(id, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL missing_wlast: got %b expected 10", r); end
    endtask

    task automatic test_concurrent();
        logic [31:0] d; logic [1:0] r; logic l; logic [3:0] id;
        aw_send(4'd0, 32'h40, 8'd0, 3'd2, 2'b01);
        w_send(32'hA, 4'hF, 1'b1);
        b_recv(id, r);
        fork
            aw_send(4'd4, 32'h40, 8'd0, 3'd2, 2'b01);
            ar_send(4'd6, 32'h40, 8'd0, 3'd2, 2'b01);
        join
        w_send(32'hB, 4'hF, 1'b1);
        b_recv(id, r);
        checks++;
        if ({id, r} !== {4'd4, 2'b00}) begin errors++; $display("FAIL conc_b: got %h/%b expected 4/00", id, r); end
        r_recv(d, r, l, id);
        checks++;
        if ({d, id} !== {32'hA, 4'd6}) begin errors++; $display("FAIL conc_old: got %h/%h expected a/6", d, id); end
        ar_send(4'd6, 32'h40, 8'd0, 3'd2, 2'b01);
        r_recv(d, r, l, id);
        checks++;
        if (d !== 32'hB) begin errors++; $display("FAIL conc_new: got %h expected b", d); end
    endtask

    task automatic test_reset_mid_burst();
        aw_send(4'd0, 32'h80, 8'd3, 3'd2, 2'b01);
        w_send(32'h1, 4'hF, 1'b0);
        ar_send(4'd0, 32'h0, 8'd3, 3'd2, 2'b01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.RVALID, bus.BVALID, bus.WREADY, bus.AWREADY, bus.ARREADY, bus.RLAST} !== 6'b0) begin
            errors++; $display("FAIL midrst_assert: got %b expected 000000",
                               {bus.RVALID, bus.BVALID, bus.WREADY, bus.AWREADY, bus.ARREADY, bus.RLAST});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.AWREADY, bus.ARREADY, bus.WREADY, bus.RVALID} !== 4'b1100) begin
            errors++; $display("FAIL midrst_release: got %b expected 1100",
                               {bus.AWREADY, bus.ARREADY, bus.WREADY, bus.RVALID});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.BVALID, bus.RVALID} !== 2'b00) begin
            errors++; $display("FAIL midrst_quiet: bvalid/rvalid got %b expected 00", {bus.BVALID, bus.RVALID});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.AWID = 4'd0; bus.AWADDR = 32'h0; bus.AWLEN = 8'd0; bus.AWSIZE = 3'd0; bus.AWBURST = 2'b00; bus.AWVALID = 1'b0;
        bus.WID = 4'd0; bus.WDATA = 32'h0; bus.WSTRB = 4'h0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARID = 4'd0; bus.ARADDR = 32'h0; bus.ARLEN = 8'd0; bus.ARSIZE = 3'd0; bus.ARBURST = 2'b00; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        test_reset();
        test_single();
        test_incr_backpressure();
        test_wrap();
        test_err_addr();
        test_err_cmd();
        test_concurrent();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

Synthesizable AXI responder: the slave end of the team's AXI interface, answering the master driver with a word-addressed on-chip memory. Write (AW/W/B) and read (AR/R) paths are independent state machines, so one write burst and one read burst can be in flight concurrently. It is the RTL slave target for master-side testbenches and a reusable scratch memory behind any AXI initiator.

## Interface
- ID_W, 4, transaction ID width
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32, with 4 strobe bits
- MEM_WORDS, 1024, memory depth in 32-bit words; power of two
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  input  4/32/8/3/2/1  write address channel
- AWREADY  output  1  write address accept
- WID/WDATA/WSTRB/WLAST/WVALID  input  4/32/4/1/1  write data channel
- WREADY  output  1  write data accept
- BID/BRESP/BVALID  output  4/2/1  write response
- BREADY  input  1  write response accept
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  input  4/32/8/3/2/1  read address channel
- ARREADY  output  1  read address accept
- RID/RDATA/RRESP/RLAST/RVALID/RSTRB  output  4/32/2/1/1/4  read data channel
- RREADY  input  1  read data accept

## Operation
- Write FSM states: WR_IDLE → WR_DATA → WR_RESP → WR_IDLE.
  - WR_IDLE: AWREADY=1. On the AW handshake, latch ID, address, LEN, SIZE and BURST, clear the beat counter, then go to WR_DATA.
  - WR_DATA: WREADY=1. Each W handshake writes the bytes selected by WSTRB at the current word, then advances the address. After beat LEN+1, go to WR_RESP.
  - WR_RESP: BVALID=1, BID is the latched ID. On the B handshake, return to WR_IDLE.
- Read FSM states: RD_IDLE → RD_DATA → RD_IDLE.
  - RD_IDLE: ARREADY=1. On the AR handshake, latch the command, then go to RD_DATA.
  - RD_DATA: RVALID=1, RLAST=1 on beat LEN only, RSTRB=4'hF. Each R handshake advances the address. After the LAST handshake, return to RD_IDLE.
- Address advance, with step = 1<<SIZE:
  - FIXED (00): address does not change.
  - INCR (01): address + step.
  - WRAP (10): address wraps within the (LEN+1)*step aligned boundary.
  - Memory index = addr[log2(MEM_WORDS)+1:2].
- Error conditions give SLVERR (2'b10). All other responses are OKAY (2'b00).
  - Triggers: SIZE>2; BURST=11; WRAP with LEN not in {1,3,7,15}; any beat address ≥ MEM_WORDS*4.
  - Errored write beats are not written. Errored read beats return RDATA=0.
  - A read error is reported per beat. A write error is sticky across the burst and reported once in BRESP.
- WLAST is not used to terminate a burst; the beat count does. If WLAST disagrees with the count (asserted early or missing on the last beat), BRESP=SLVERR.
- WID is ignored, since only one write is outstanding.
- Memory contents are not initialised or cleared by reset.

## Timing
- Reset values: AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0, RLAST=0. BID, BRESP, RID, RDATA, RRESP and RSTRB are all 0. The first cycle after reset release has AWREADY=ARREADY=1.
- All outputs come from registers; there is no combinational path from input to output.
- Write latency:
  - WREADY rises in the cycle after the AW handshake.
  - BVALID rises in the cycle after the final W handshake.
  - Minimum total is LEN+3 cycles from AW handshake to the B handshake.
- Read latency:
  - The first RVALID comes in the cycle after the AR handshake.
  - With RREADY held high, beats follow back-to-back at one per cycle.
- When VALID is high and READY is low, every R and B output holds stable until the handshake.
- AWREADY is low outside WR_IDLE and ARREADY is low outside RD_IDLE. This backpressures any new command.
- Read and write to the same word in the same cycle: the read beat returns the old data. Read data is registered at beat launch; the write commits at the W handshake edge.
- An address crossing the memory top mid-burst errors only the out-of-range beats. There is no wrap-around to word 0.
- Reset asserted mid-burst: both FSMs go to IDLE immediately and the in-flight bursts are dropped. No B or R is issued for them.

## Structure
- Package axi_slv_pkg holds:
  - burst encodings FIXED/INCR/WRAP;
  - response constants OKAY/SLVERR;
  - enums for the write and read FSM states;
  - a struct for the latched command (id, addr, len, size, burst).
- Sub-module axi_addr_gen: combinational next-address and error-check unit, taking addr, len, size and burst. It is instantiated twice, once each for the write and read paths.
- The memory is a byte-enabled register array inside axi_slave_mem.

## Test plan
- Single write then read: AW INCR addr 0x10, LEN 0, WDATA 0xDEADBEEF, WSTRB F; then AR at the same address → BRESP OKAY, RDATA 0xDEADBEEF, RLAST=1.
- INCR burst with backpressure: AW addr 0x0, LEN 3, data 1..4; RREADY toggled 1,0,1,0 → R returns 1,2,3,4 with RDATA held during stalls, and RLAST on beat 4 only.
- WRAP: write words 0..3; then AR WRAP addr 0x8, LEN 3, SIZE 2 → reads come from addresses 0x8, 0xC, 0x0, 0x4.
- Errors:
  - AWADDR = MEM_WORDS*4 → BRESP SLVERR and memory unchanged.
  - ARSIZE=3 → every beat RRESP SLVERR, RDATA 0.
  - Early WLAST on a LEN 1 burst → BRESP SLVERR.
- Concurrency: AW and AR to the same word in the same cycle, with old value 0xA and new value 0xB → read returns 0xA, later read returns 0xB. Assert rst_n mid-burst → all VALIDs go to 0 at once, and AWREADY=ARREADY=1 after release.
